// File: rtl/sorcerer_cass_fsk_decoder.sv
// Cassette FSK decoder: times CASS_IN half-periods, recovers KCS bits at 300 or
// 1200 baud and frames them into characters behind a DAV/RD_STB handshake.
module sorcerer_cass_fsk_decoder #(
  parameter int DATA_BITS      = 8,
  parameter int CNT_W          = 8,
  parameter int THR_300        = 12,
  parameter int THR_1200       = 24,
  parameter int GLITCH         = 3,
  parameter int TIMEOUT        = 96,
  parameter int CARRIER_HALVES = 16
) (
  input  logic                 i_clk12,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_enable,
  input  logic                 i_baud_sel,
  input  logic                 i_cass_in,
  input  logic                 i_rd_stb,
  output logic [DATA_BITS-1:0] o_dout,
  output logic                 o_dav,
  output logic                 o_fe,
  output logic                 o_ovr,
  output logic                 o_carrier
);

  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] C_GLITCH   = CNT_W'(GLITCH);
  localparam logic [CNT_W-1:0] C_THR_300  = CNT_W'(THR_300);
  localparam logic [CNT_W-1:0] C_THR_1200 = CNT_W'(THR_1200);
  localparam logic [CNT_W-1:0] C_CARRIER  = CNT_W'(CARRIER_HALVES);
  localparam logic [BC_W-1:0]  C_LAST_BIT = BC_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

  logic                 r_sync1, r_sync2, r_sync3;
  logic                 r_baud_q;
  logic [CNT_W-1:0]     r_hp;
  logic                 r_cls_vld, r_cls_short, r_prev_short;
  logic [CNT_W-1:0]     r_nh;
  logic [CNT_W-1:0]     r_vcnt;
  logic                 r_carrier;
  state_t               r_state;
  logic [BC_W-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_dav, r_fe, r_ovr;

  logic                 w_edge, w_clear, w_accept, w_timeout, w_flush;
  logic [CNT_W-1:0]     w_thr, w_long_n, w_short_n, w_nh_inc, w_vcnt_next;
  logic                 w_bit_emit, w_bit_val;
  state_t               w_state_next;
  logic                 w_shift_en, w_complete;

  // Third flop only serves the edge detector; the first two resolve metastability.
  always_ff @(posedge i_clk12 or posedge i_reset) begin
    if (i_reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_baud_q <= 1'b0;
    end else begin
      // NOTE: clocked state always uses <= so every flop samples pre-edge values.
      r_sync1  <= i_cass_in;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      r_baud_q <= i_baud_sel;
    end
  end

  assign w_edge    = r_sync2 ^ r_sync3;
  assign w_clear   = !i_enable || (i_baud_sel != r_baud_q);
  assign w_accept  = w_edge && (r_hp >= C_GLITCH) && !w_clear;
  assign w_timeout = !w_clear && !w_accept && i_tick && (r_hp == C_TIMEOUT - CNT_W'(1));
  assign w_flush   = w_clear || w_timeout;
  assign w_thr     = i_baud_sel ? C_THR_1200 : C_THR_300;
  assign w_long_n  = i_baud_sel ? CNT_W'(2) : CNT_W'(8);
  assign w_short_n = w_long_n << 1;

  // Half-period timer and classification stage.
  always_ff @(posedge i_clk12 or posedge i_reset) begin
    if (i_reset) begin
      r_hp        <= '0;
      r_cls_vld   <= 1'b0;
      r_cls_short <= 1'b0;
    end else begin
      r_cls_vld <= w_accept;
      if (w_accept) r_cls_short <= (r_hp < w_thr);
      if (w_clear || w_accept)               r_hp <= '0;
      else if (i_tick && r_hp != C_TIMEOUT)  r_hp <= r_hp + CNT_W'(1);
    end
  end

  // A class change restarts the run, so bit cells resynchronise on their own.
  assign w_nh_inc    = (r_cls_short == r_prev_short) ? r_nh + CNT_W'(1) : CNT_W'(1);
  assign w_bit_val   = r_cls_short;
  assign w_bit_emit  = r_cls_vld && !w_flush &&
                       (r_cls_short ? (w_nh_inc == w_short_n) : (w_nh_inc == w_long_n));
  assign w_vcnt_next = w_flush ? '0 :
                       (r_cls_vld && r_vcnt != C_CARRIER) ? r_vcnt + CNT_W'(1) : r_vcnt;

  always_ff @(posedge i_clk12 or posedge i_reset) begin
    if (i_reset) begin
      r_nh         <= '0;
      r_prev_short <= 1'b0;
      r_vcnt       <= '0;
      r_carrier    <= 1'b0;
    end else begin
      r_vcnt    <= w_vcnt_next;
      r_carrier <= (w_vcnt_next == C_CARRIER);
      if (w_flush) begin
        r_nh <= '0;
      end else if (r_cls_vld) begin
        r_prev_short <= r_cls_short;
        r_nh         <= w_bit_emit ? '0 : w_nh_inc;
      end
    end
  end

  always_ff @(posedge i_clk12 or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a latch behind.
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_complete   = 1'b0;
    if (w_flush) begin
      w_state_next = S_IDLE;
    end else if (w_bit_emit) begin
      unique case (r_state)
        S_IDLE: if (!w_bit_val && r_carrier) w_state_next = S_DATA;
        S_DATA: begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == C_LAST_BIT) w_state_next = S_STOP;
        end
        S_STOP: begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk12 or posedge i_reset) begin
    if (i_reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state != S_DATA) r_bit_cnt <= '0;
      else if (w_shift_en)   r_bit_cnt <= r_bit_cnt + BC_W'(1);
      if (w_shift_en) r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
    end
  end

  // Completion outranks a coincident read: the fresh character stays visible.
  always_ff @(posedge i_clk12 or posedge i_reset) begin
    if (i_reset) begin
      r_dout <= '0;
      r_dav  <= 1'b0;
      r_fe   <= 1'b0;
      r_ovr  <= 1'b0;
    end else if (w_complete) begin
      r_dout <= r_shift;
      r_dav  <= 1'b1;
      r_fe   <= ~w_bit_val;
      r_ovr  <= ~i_rd_stb & (r_ovr | r_dav);
    end else if (i_rd_stb) begin
      r_dav <= 1'b0;
      r_fe  <= 1'b0;
      r_ovr <= 1'b0;
    end
  end

  assign o_dout    = r_dout;
  assign o_dav     = r_dav;
  assign o_fe      = r_fe;
  assign o_ovr     = r_ovr;
  assign o_carrier = r_carrier;

endmodule

// File: tb/tb_sorcerer_cass_fsk_decoder.sv
// Bench for the cassette FSK decoder: synthesises KCS waveforms from bytes and
// compares the handshake outputs against a character-level model.
module tb_sorcerer_cass_fsk_decoder;

  logic       clk = 1'b0;
  logic       rst, tick, en, baud, cass, rd;
  logic [7:0] dout;
  logic       dav, fe, ovr, carrier;

  int checks = 0;
  int errors = 0;

  // Character-level model of the host-visible state.
  logic [7:0] m_dout;
  logic       m_dav, m_fe, m_ovr;

  sorcerer_cass_fsk_decoder dut (
    .i_clk12(clk), .i_reset(rst), .i_tick(tick), .i_enable(en),
    .i_baud_sel(baud), .i_cass_in(cass), .i_rd_stb(rd),
    .o_dout(dout), .o_dav(dav), .o_fe(fe), .o_ovr(ovr), .o_carrier(carrier)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic half(input int t);
    cyc(t);
    cass = ~cass;
  endtask

  // Real half with a 2-tick pulse placed just after the preceding real edge.
  task automatic glitch_half(input int t);
    cyc(1); cass = ~cass;
    cyc(2); cass = ~cass;
    cyc(t - 3); cass = ~cass;
  endtask

  task automatic send_bit(input bit v);
    if (baud) begin
      if (v) repeat (4) half(16); else repeat (2) half(32);
    end else begin
      if (v) repeat (16) half(8); else repeat (8) half(16);
    end
  endtask

  task automatic leader(input bit glitchy);
    int n = baud ? 32 : 64;
    int t = baud ? 16 : 8;
    for (int i = 0; i < n; i++) if (glitchy) glitch_half(t); else half(t);
  endtask

  task automatic model_complete(input logic [7:0] b, input bit stop, input bit rd_hit);
    m_ovr  = rd_hit ? 1'b0 : (m_ovr | m_dav);
    m_dav  = 1'b1;
    m_dout = b;
    m_fe   = !stop;
  endtask

  // rd_hit places RD_STB in the cycle the character completes (edge->classify 3, +1).
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit rd_hit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    if (rd_hit) begin
      cyc(3); rd = 1'b1; cyc(1); rd = 1'b0;
    end
    model_complete(b, stop, rd_hit);
  endtask

  task automatic do_read();
    rd = 1'b1; cyc(1); rd = 1'b0;
    m_dav = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; en = 1'b0; baud = 1'b0; cass = 1'b0; rd = 1'b0;
    m_dout = '0; m_dav = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    cyc(3);
    @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (dav !== 1'b0) begin errors++; $display("FAIL reset_dav got %b exp 0", dav); end
    checks++; if (fe !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", fe); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", ovr); end
    checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL reset_carrier got %b exp 0", carrier); end
    cyc(1); rst = 1'b0; en = 1'b1; cyc(2);
  endtask

  task automatic test_1200_basic();
    baud = 1'b1; cyc(2);
    leader(1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    cyc(6); @(negedge clk);
    checks++; if (dout !== m_dout) begin errors++; $display("FAIL b1200_dout got %h exp %h", dout, m_dout); end
    checks++; if (dav !== 1'b1) begin errors++; $display("FAIL b1200_dav got %b exp 1", dav); end
    checks++; if (fe !== 1'b0) begin errors++; $display("FAIL b1200_fe got %b exp 0", fe); end
    checks++; if (carrier !== 1'b1) begin errors++; $display("FAIL b1200_carrier got %b exp 1", carrier); end
    #1;
  endtask

  task automatic test_300_basic();
    do_read();
    baud = 1'b0; cyc(2);
    leader(1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    cyc(6); @(negedge clk);
    checks++; if (dout !== m_dout) begin errors++; $display("FAIL b300_dout got %h exp %h", dout, m_dout); end
    checks++; if (dav !== m_dav) begin errors++; $display("FAIL b300_dav got %b exp %b", dav, m_dav); end
    checks++; if (fe !== m_fe) begin errors++; $display("FAIL b300_fe got %b exp %b", fe, m_fe); end
    #1;
  endtask

  task automatic test_framing_error();
    do_read();
    baud = 1'b1; cyc(2);
    leader(1'b0);
    send_frame(8'hA5, 1'b0, 1'b0);
    cyc(6); @(negedge clk);
    checks++; if (dout !== m_dout) begin errors++; $display("FAIL fe_dout got %h exp %h", dout, m_dout); end
    checks++; if (dav !== 1'b1) begin errors++; $display("FAIL fe_dav got %b exp 1", dav); end
    checks++; if (fe !== 1'b1) begin errors++; $display("FAIL fe_flag got %b exp 1", fe); end
    #1;
    do_read();
    @(negedge clk);
    checks++; if (dav !== 1'b0) begin errors++; $display("FAIL fe_read_dav got %b exp 0", dav); end
    checks++; if (fe !== 1'b0) begin errors++; $display("FAIL fe_read_fe got %b exp 0", fe); end
    #1;
  endtask

  task automatic test_back_to_back();
    leader(1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    cyc(6); @(negedge clk);
    checks++; if (dout !== 8'h22) begin errors++; $display("FAIL ovr_dout got %h exp 22", dout); end
    checks++; if (ovr !== m_ovr) begin errors++; $display("FAIL ovr_flag got %b exp %b", ovr, m_ovr); end
    checks++; if (dav !== 1'b1) begin errors++; $display("FAIL ovr_dav got %b exp 1", dav); end
    #1;
    send_frame(8'h33, 1'b1, 1'b1);
    cyc(2); @(negedge clk);
    checks++; if (dout !== m_dout) begin errors++; $display("FAIL rdhit_dout got %h exp %h", dout, m_dout); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL rdhit_ovr got %b exp 0", ovr); end
    checks++; if (dav !== 1'b1) begin errors++; $display("FAIL rdhit_dav got %b exp 1", dav); end
    #1;
  endtask

  task automatic test_glitch_timeout();
    logic [7:0] b;
    do_read();
    b = 8'($urandom);
    leader(1'b1);
    send_frame(b, 1'b1, 1'b0);
    cyc(6); @(negedge clk);
    checks++; if (dout !== m_dout) begin errors++; $display("FAIL glitch_dout got %h exp %h", dout, m_dout); end
    checks++; if (fe !== 1'b0) begin errors++; $display("FAIL glitch_fe got %b exp 0", fe); end
    #1;
    do_read();
    b = 8'($urandom);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    cyc(100); @(negedge clk);
    checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL timeout_carrier got %b exp 0", carrier); end
    checks++; if (dav !== m_dav) begin errors++; $display("FAIL timeout_dav got %b exp %b", dav, m_dav); end
    #1;
    b = 8'($urandom);
    leader(1'b0);
    send_frame(b, 1'b1, 1'b0);
    cyc(6); @(negedge clk);
    checks++; if (dout !== m_dout) begin errors++; $display("FAIL after_timeout_dout got %h exp %h", dout, m_dout); end
    checks++; if (dav !== m_dav) begin errors++; $display("FAIL after_timeout_dav got %b exp %b", dav, m_dav); end
    #1;
  endtask

  task automatic test_reset_mid_byte();
    leader(1'b0);
    send_frame(8'($urandom), 1'b1, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midrst_dout got %h exp 00", dout); end
    checks++; if (dav !== 1'b0) begin errors++; $display("FAIL midrst_dav got %b exp 0", dav); end
    checks++; if (carrier !== 1'b0) begin errors++; $display("FAIL midrst_carrier got %b exp 0", carrier); end
    m_dout = '0; m_dav = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    cyc(2); rst = 1'b0; cyc(2);
    leader(1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    cyc(6); @(negedge clk);
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL postrst_dout got %h exp 5A", dout); end
    checks++; if (dav !== 1'b1) begin errors++; $display("FAIL postrst_dav got %b exp 1", dav); end
    checks++; if (fe !== 1'b0) begin errors++; $display("FAIL postrst_fe got %b exp 0", fe); end
    #1;
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit stop, rd_hit;
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(1, 0) == 1) do_read();
      baud   = 1'($urandom_range(1, 0));
      b      = 8'($urandom);
      stop   = ($urandom_range(3, 0) != 0);
      rd_hit = ($urandom_range(2, 0) == 0);
      cyc(2);
      leader(1'b0);
      send_frame(b, stop, rd_hit);
      cyc(6); @(negedge clk);
      checks++; if (dout !== m_dout) begin errors++; $display("FAIL rnd%0d_dout got %h exp %h", it, dout, m_dout); end
      checks++; if (dav !== m_dav) begin errors++; $display("FAIL rnd%0d_dav got %b exp %b", it, dav, m_dav); end
      checks++; if (fe !== m_fe) begin errors++; $display("FAIL rnd%0d_fe got %b exp %b", it, fe, m_fe); end
      checks++; if (ovr !== m_ovr) begin errors++; $display("FAIL rnd%0d_ovr got %b exp %b", it, ovr, m_ovr); end
      checks++; if (carrier !== 1'b1) begin errors++; $display("FAIL rnd%0d_carrier got %b exp 1", it, carrier); end
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_1200_basic();
    test_300_basic();
    test_framing_error();
    test_back_to_back();
    test_glitch_timeout();
    test_reset_mid_byte();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
